// File: rtl/seat_alloc_arbiter_if.sv
// Kiosk-side request/response bundle of seat_alloc_arbiter.
// master = kiosk requesters, slave = the arbiter.
interface seat_alloc_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int SEAT_W = 6
);
    logic [N_REQ-1:0]        req_valid;
    logic [2*N_REQ-1:0]      req_op;
    logic [SEAT_W*N_REQ-1:0] req_seat;
    logic [N_REQ-1:0]        req_ready;
    logic                    rsp_valid;
    logic [2:0]              rsp_id;
    logic [2:0]              rsp_status;

    modport master (
        output req_valid, req_op, req_seat,
        input  req_ready, rsp_valid, rsp_id, rsp_status
    );

    modport slave (
        input  req_valid, req_op, req_seat,
        output req_ready, rsp_valid, rsp_id, rsp_status
    );
endinterface

// File: rtl/seat_alloc_arbiter.sv
// Round-robin arbiter serialising reserve/release/renew requests onto the seat table,
// with minute-tick expiry and daily clear. Optional SEAT_ALLOC_STATS_EN adds grant/reject counters.
module seat_alloc_arbiter #(
    parameter int N_REQ     = 4,
    parameter int NUM_SEATS = 32,
    parameter int SEAT_W    = 6,
    parameter int HOLD_MIN  = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seat_alloc_arbiter_if.slave   bus,
    input  logic                  min_tick,
    input  logic                  day_clear,
    output logic [NUM_SEATS-1:0]  seat_map,
    output logic [SEAT_W:0]       occupied_cnt
`ifdef SEAT_ALLOC_STATS_EN
    ,
    output logic [15:0]           grant_cnt,
    output logic [15:0]           reject_cnt
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_CHECK, S_RESP} state_t;
    typedef enum logic [1:0] {OP_RESERVE = 2'd0, OP_RELEASE = 2'd1, OP_RENEW = 2'd2, OP_ILLEGAL = 2'd3} op_t;
    typedef enum logic [2:0] {ST_OK = 3'd0, ST_OCCUPIED = 3'd1, ST_NOT_OWNER = 3'd2,
                              ST_BAD_SEAT = 3'd3, ST_ABORTED = 3'd4} status_t;

    state_t              state;
    logic [2:0]          ptr;
    logic [2:0]          w_id;
    op_t                 w_op;
    logic [SEAT_W-1:0]   w_seat;

    logic [NUM_SEATS-1:0] occ;
    logic [2:0]           owner [NUM_SEATS];
    logic [5:0]           cnt   [NUM_SEATS];

    logic [NUM_SEATS-1:0] occ_nxt;
    logic [2:0]           owner_nxt [NUM_SEATS];
    logic [5:0]           cnt_nxt   [NUM_SEATS];
    logic [SEAT_W:0]      pop_nxt;

    logic       any_req;
    logic [2:0] win;
    logic       cur_occ;
    logic [2:0] cur_owner;
    status_t    status;
    logic       tbl_write;

    assign seat_map = occ;

    // Round robin: the lowest offset from ptr+1 wins, so the loop runs from the far end down.
    always_comb begin
        any_req = |bus.req_valid;
        win     = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            if (bus.req_valid[(int'(ptr) + k) % N_REQ]) win = 3'((int'(ptr) + k) % N_REQ);
        end
    end

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        cur_occ   = 1'b0;
        cur_owner = '0;
        for (int i = 0; i < NUM_SEATS; i++) begin
            if (SEAT_W'(i) == w_seat) begin
                cur_occ   = occ[i];
                cur_owner = owner[i];
            end
        end
        if ({1'b0, w_seat} >= (SEAT_W+1)'(NUM_SEATS) || w_op == OP_ILLEGAL) status = ST_BAD_SEAT;
        else if (w_op == OP_RESERVE && cur_occ)                               status = ST_OCCUPIED;
        else if (w_op != OP_RESERVE && (!cur_occ || cur_owner != w_id))       status = ST_NOT_OWNER;
        else                                                                  status = ST_OK;
    end

    assign tbl_write = (state == S_CHECK) && (status == ST_OK);

    // Priority per seat: daily clear, then the transaction write, then minute expiry.
    always_comb begin
        occ_nxt   = occ;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        pop_nxt   = '0;
        for (int i = 0; i < NUM_SEATS; i++) begin
            if (day_clear) begin
                occ_nxt[i]   = 1'b0;
                owner_nxt[i] = '0;
                cnt_nxt[i]   = '0;
            end else if (tbl_write && SEAT_W'(i) == w_seat) begin
                case (w_op)
                    OP_RESERVE: begin
                        occ_nxt[i]   = 1'b1;
                        owner_nxt[i] = w_id;
                        cnt_nxt[i]   = 6'(HOLD_MIN);
                    end
                    OP_RENEW:   cnt_nxt[i] = 6'(HOLD_MIN);
                    OP_RELEASE: begin
                        occ_nxt[i] = 1'b0;
                        cnt_nxt[i] = '0;
                    end
                    default: ;
                endcase
            end else if (min_tick && occ[i] && cnt[i] != '0) begin
                cnt_nxt[i] = cnt[i] - 6'd1;
                if (cnt[i] == 6'd1) occ_nxt[i] = 1'b0;
            end
            pop_nxt = pop_nxt + (SEAT_W+1)'(occ_nxt[i]);
        end
    end

    // NOTE: the table is small and its reset state is architecturally visible, so every entry is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ          <= '0;
            occupied_cnt <= '0;
            for (int i = 0; i < NUM_SEATS; i++) begin
                owner[i] <= '0;
                cnt[i]   <= '0;
            end
        end else begin
            occ          <= occ_nxt;
            owner        <= owner_nxt;
            cnt          <= cnt_nxt;
            occupied_cnt <= pop_nxt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            ptr            <= 3'(N_REQ - 1);
            w_id           <= '0;
            w_op           <= OP_RESERVE;
            w_seat         <= '0;
            bus.req_ready  <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_status <= '0;
        end else begin
            bus.req_ready <= '0;
            bus.rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req && !day_clear) begin
                        w_id          <= win;
                        w_op          <= op_t'(bus.req_op[2*int'(win) +: 2]);
                        w_seat        <= bus.req_seat[SEAT_W*int'(win) +: SEAT_W];
                        bus.req_ready <= N_REQ'(1) << win;
                        state         <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    ptr   <= w_id;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    bus.rsp_valid  <= 1'b1;
                    bus.rsp_id     <= w_id;
                    bus.rsp_status <= status;
                    state          <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
            // An in-flight transaction is answered with ABORTED when the table is wiped under it.
            if (day_clear && state != S_IDLE) begin
                bus.rsp_valid  <= 1'b1;
                bus.rsp_id     <= w_id;
                bus.rsp_status <= ST_ABORTED;
                state          <= S_RESP;
            end
        end
    end

`ifdef SEAT_ALLOC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt  <= '0;
            reject_cnt <= '0;
        end else begin
            if (|bus.req_ready && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
            if (bus.rsp_valid && bus.rsp_status != ST_OK && reject_cnt != 16'hFFFF)
                reject_cnt <= reject_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_seat_alloc_arbiter.sv
// Directed self-checking bench for seat_alloc_arbiter, built with HOLD_MIN=3 so expiry is short.
module tb_seat_alloc_arbiter;
    localparam int N_REQ     = 4;
    localparam int NUM_SEATS = 32;
    localparam int SEAT_W    = 6;
    localparam int HOLD_MIN  = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 min_tick;
    logic                 day_clear;
    logic [NUM_SEATS-1:0] seat_map;
    logic [SEAT_W:0]      occupied_cnt;

    int errors = 0;
    int checks = 0;

    seat_alloc_arbiter_if #(.N_REQ(N_REQ), .SEAT_W(SEAT_W)) bus ();

    seat_alloc_arbiter #(
        .N_REQ(N_REQ), .NUM_SEATS(NUM_SEATS), .SEAT_W(SEAT_W), .HOLD_MIN(HOLD_MIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .min_tick(min_tick), .day_clear(day_clear),
        .seat_map(seat_map), .occupied_cnt(occupied_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_min();
        min_tick = 1'b1;
        tick();
        min_tick = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_seat  = '0;
        min_tick      = 1'b0;
        day_clear     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Issues one request and waits (bounded) for its grant and response.
    task automatic do_req(input int id, input logic [1:0] op, input logic [5:0] seat,
                          output logic [2:0] st, output logic [2:0] rid,
                          output int g_lat, output int r_lat);
        bus.req_valid[id]        = 1'b1;
        bus.req_op[2*id +: 2]    = op;
        bus.req_seat[6*id +: 6]  = seat;
        g_lat = 0;
        do begin tick(); g_lat++; end while (bus.req_ready[id] !== 1'b1 && g_lat < 20);
        bus.req_valid[id] = 1'b0;
        checks++;
        if (bus.req_ready[id] !== 1'b1) begin
            errors++;
            $display("FAIL grant_wait id=%0d: got req_ready=%b want bit set within 20 cycles", id, bus.req_ready);
        end
        r_lat = 0;
        do begin tick(); r_lat++; end while (bus.rsp_valid !== 1'b1 && r_lat < 20);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_wait id=%0d: got rsp_valid=%b want 1 within 20 cycles", id, bus.rsp_valid);
        end
        st  = bus.rsp_status;
        rid = bus.rsp_id;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_op = '0; bus.req_seat = '0;
        min_tick = 1'b0; day_clear = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_status, seat_map, occupied_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b rsp_valid=%b id=%0d st=%0d map=%h cnt=%0d want all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_status, seat_map, occupied_cnt);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got ready=%b rsp_valid=%b want 0/0", bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_reserve();
        logic [2:0] st, rid; int gl, rl;
        do_req(0, 2'b00, 6'd5, st, rid, gl, rl);
        checks++;
        if (gl !== 1) begin errors++; $display("FAIL grant_latency: got %0d want 1", gl); end
        checks++;
        if (rl !== 2) begin errors++; $display("FAIL rsp_latency: got %0d want 2", rl); end
        checks++;
        if (rid !== 3'd0 || st !== 3'd0) begin
            errors++; $display("FAIL reserve_rsp: got id=%0d st=%0d want id=0 st=0", rid, st);
        end
        checks++;
        if (seat_map !== 32'h0000_0020 || occupied_cnt !== 7'd1) begin
            errors++; $display("FAIL reserve_table: got map=%h cnt=%0d want 00000020/1", seat_map, occupied_cnt);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_pulse_width: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_conflict();
        logic [2:0] st, rid; int gl, rl;
        do_req(1, 2'b00, 6'd5, st, rid, gl, rl);
        checks++;
        if (rid !== 3'd1 || st !== 3'd1) begin
            errors++; $display("FAIL occupied_rsp: got id=%0d st=%0d want id=1 st=1", rid, st);
        end
        do_req(1, 2'b01, 6'd5, st, rid, gl, rl);
        checks++;
        if (st !== 3'd2) begin errors++; $display("FAIL not_owner_release: got st=%0d want 2", st); end
        checks++;
        if (seat_map !== 32'h0000_0020) begin errors++; $display("FAIL foreign_release_map: got %h want 00000020", seat_map); end
        do_req(0, 2'b01, 6'd5, st, rid, gl, rl);
        checks++;
        if (st !== 3'd0 || seat_map !== 32'h0 || occupied_cnt !== 7'd0) begin
            errors++; $display("FAIL owner_release: got st=%0d map=%h cnt=%0d want 0/0/0", st, seat_map, occupied_cnt);
        end
    endtask

    task automatic test_round_robin();
        int gid[5]; int gcyc[5]; int ng; int cyc;
        ng = 0; cyc = 0;
        apply_reset();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_op[2*i +: 2]   = 2'b01;
            bus.req_seat[6*i +: 6] = 6'd10;
        end
        bus.req_valid = '1;
        while (ng < 5 && cyc < 40) begin
            tick();
            cyc++;
            if (bus.req_ready !== 4'b0) begin
                checks++;
                if (!$onehot(bus.req_ready)) begin
                    errors++; $display("FAIL ready_onehot: got %b want one-hot", bus.req_ready);
                end
                for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) gid[ng] = i;
                gcyc[ng] = cyc;
                ng++;
            end
        end
        bus.req_valid = '0;
        checks++;
        if (ng != 5) begin errors++; $display("FAIL rr_grant_count: got %0d want 5", ng); end
        checks++;
        if (ng > 0 && gcyc[0] != 1) begin errors++; $display("FAIL rr_first_latency: got %0d want 1", gcyc[0]); end
        for (int k = 0; k < ng; k++) begin
            checks++;
            if (gid[k] != k % N_REQ) begin
                errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, gid[k], k % N_REQ);
            end
        end
        for (int k = 1; k < ng; k++) begin
            checks++;
            if (gcyc[k] - gcyc[k-1] != 4) begin
                errors++; $display("FAIL rr_spacing[%0d]: got %0d want 4", k, gcyc[k] - gcyc[k-1]);
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_expiry();
        logic [2:0] st, rid; int gl, rl;
        do_req(0, 2'b00, 6'd2, st, rid, gl, rl);
        pulse_min();
        pulse_min();
        checks++;
        if (seat_map !== 32'h4) begin errors++; $display("FAIL expiry_2ticks: got %h want 00000004", seat_map); end
        pulse_min();
        checks++;
        if (seat_map !== 32'h0 || occupied_cnt !== 7'd0) begin
            errors++; $display("FAIL expiry_3ticks: got map=%h cnt=%0d want 0/0", seat_map, occupied_cnt);
        end
        do_req(0, 2'b00, 6'd2, st, rid, gl, rl);
        pulse_min();
        do_req(0, 2'b10, 6'd2, st, rid, gl, rl);
        checks++;
        if (st !== 3'd0) begin errors++; $display("FAIL renew_rsp: got st=%0d want 0", st); end
        pulse_min();
        pulse_min();
        checks++;
        if (seat_map !== 32'h4) begin errors++; $display("FAIL renew_2ticks: got %h want 00000004", seat_map); end
        pulse_min();
        checks++;
        if (seat_map !== 32'h0) begin errors++; $display("FAIL renew_3ticks: got %h want 0", seat_map); end
    endtask

    task automatic test_tick_write_collision();
        logic [2:0] st, rid; int gl, rl; int n;
        do_req(3, 2'b00, 6'd8, st, rid, gl, rl);
        bus.req_valid[2]       = 1'b1;
        bus.req_op[4 +: 2]     = 2'b00;
        bus.req_seat[12 +: 6]  = 6'd7;
        n = 0;
        do begin tick(); n++; end while (bus.req_ready[2] !== 1'b1 && n < 20);
        bus.req_valid[2] = 1'b0;
        tick();
        min_tick = 1'b1;
        tick();
        min_tick = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 3'd0 || seat_map !== 32'h180) begin
            errors++; $display("FAIL collision_rsp: got v=%b st=%0d map=%h want 1/0/00000180",
                               bus.rsp_valid, bus.rsp_status, seat_map);
        end
        pulse_min();
        pulse_min();
        checks++;
        if (seat_map !== 32'h80 || occupied_cnt !== 7'd1) begin
            errors++; $display("FAIL collision_2ticks: got map=%h cnt=%0d want 00000080/1", seat_map, occupied_cnt);
        end
        pulse_min();
        checks++;
        if (seat_map !== 32'h0) begin errors++; $display("FAIL collision_3ticks: got %h want 0", seat_map); end
    endtask

    task automatic test_bad_seat();
        logic [2:0] st, rid; int gl, rl;
        logic [5:0] seats [3];
        logic [1:0] ops   [3];
        seats = '{6'd40, 6'd32, 6'd1};
        ops   = '{2'b00, 2'b00, 2'b11};
        do_req(0, 2'b00, 6'd1, st, rid, gl, rl);
        for (int k = 0; k < 3; k++) begin
            do_req(3, ops[k], seats[k], st, rid, gl, rl);
            checks++;
            if (st !== 3'd3 || rid !== 3'd3) begin
                errors++; $display("FAIL bad_seat[%0d]: got id=%0d st=%0d want id=3 st=3", k, rid, st);
            end
        end
        checks++;
        if (seat_map !== 32'h2 || occupied_cnt !== 7'd1) begin
            errors++; $display("FAIL bad_seat_table: got map=%h cnt=%0d want 00000002/1", seat_map, occupied_cnt);
        end
        do_req(2, 2'b00, 6'd31, st, rid, gl, rl);
        checks++;
        if (st !== 3'd0 || seat_map !== 32'h8000_0002 || occupied_cnt !== 7'd2) begin
            errors++; $display("FAIL last_seat: got st=%0d map=%h cnt=%0d want 0/80000002/2", st, seat_map, occupied_cnt);
        end
    endtask

    task automatic test_day_clear();
        int n;
        bus.req_valid[1]     = 1'b1;
        bus.req_op[2 +: 2]   = 2'b00;
        bus.req_seat[6 +: 6] = 6'd9;
        n = 0;
        do begin tick(); n++; end while (bus.req_ready[1] !== 1'b1 && n < 20);
        bus.req_valid[1] = 1'b0;
        tick();
        day_clear = 1'b1;
        tick();
        day_clear = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 3'd4 || bus.rsp_id !== 3'd1) begin
            errors++; $display("FAIL abort_rsp: got v=%b st=%0d id=%0d want 1/4/1",
                               bus.rsp_valid, bus.rsp_status, bus.rsp_id);
        end
        checks++;
        if (seat_map !== 32'h0 || occupied_cnt !== 7'd0) begin
            errors++; $display("FAIL clear_table: got map=%h cnt=%0d want 0/0", seat_map, occupied_cnt);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_pulse_width: got %b want 0", bus.rsp_valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [2:0] st, rid; int gl, rl; int n; int seen;
        do_req(0, 2'b00, 6'd4, st, rid, gl, rl);
        bus.req_valid[2]      = 1'b1;
        bus.req_op[4 +: 2]    = 2'b00;
        bus.req_seat[12 +: 6] = 6'd3;
        n = 0;
        do begin tick(); n++; end while (bus.req_ready[2] !== 1'b1 && n < 20);
        bus.req_valid[2] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 1'b0 || seat_map !== 32'h0 || occupied_cnt !== 7'd0) begin
            errors++; $display("FAIL async_reset: got ready=%b v=%b map=%h cnt=%0d want all 0",
                               bus.req_ready, bus.rsp_valid, seat_map, occupied_cnt);
        end
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            if (bus.rsp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL no_rsp_after_reset: got %0d responses want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_reserve();
        test_conflict();
        test_round_robin();
        test_expiry();
        test_tick_write_collision();
        test_bad_seat();
        test_day_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
